// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID-stage hazard controller and the pipeline it steers.
// master drives the pipeline status and consumes the stall/flush controls; slave is the controller.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              memread_idex_i;
  logic [REG_AW-1:0] rt_idex_i;
  logic [REG_AW-1:0] rs_ifid_i;
  logic [REG_AW-1:0] rt_ifid_i;
  logic              use_rs_ifid_i;
  logic              use_rt_ifid_i;
  logic              branch_taken_i;
  logic              mem_wait_i;
  logic              pc_stall_o;
  logic              ifid_stall_o;
  logic              idex_nop_o;
  logic              ifid_flush_o;
  logic              idex_flush_o;
  logic              freeze_o;
  logic              busy_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output memread_idex_i, rt_idex_i, rs_ifid_i, rt_ifid_i,
           use_rs_ifid_i, use_rt_ifid_i, branch_taken_i, mem_wait_i,
    input  pc_stall_o, ifid_stall_o, idex_nop_o, ifid_flush_o,
           idex_flush_o, freeze_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  memread_idex_i, rt_idex_i, rs_ifid_i, rt_ifid_i,
           use_rs_ifid_i, use_rt_ifid_i, branch_taken_i, mem_wait_i,
    output pc_stall_o, ifid_stall_o, idex_nop_o, ifid_flush_o,
           idex_flush_o, freeze_o, busy_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / memory-freeze controller for the 5-stage MIPS pipeline.
// A load-use hazard inserts LOAD_LAT bubbles; bubble cycles are counted in a saturating counter.
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  hazard_ctrl_if.slave  bus
);
  typedef enum logic {IDLE, LDSTALL} state_t;

  state_t           state, state_n;
  logic [2:0]       rem, rem_n;
  logic [CNT_W-1:0] stall_cnt;
  logic             hit;

  // A load to $zero never hazards, and only operand fields actually read can match.
  assign hit = bus.memread_idex_i && (bus.rt_idex_i != '0) &&
               ((bus.use_rs_ifid_i && (bus.rs_ifid_i == bus.rt_idex_i)) ||
                (bus.use_rt_ifid_i && (bus.rt_ifid_i == bus.rt_idex_i)));

  always_comb begin
    state_n          = state;
    rem_n            = rem;
    bus.pc_stall_o   = 1'b0;
    bus.ifid_stall_o = 1'b0;
    bus.idex_nop_o   = 1'b0;
    bus.ifid_flush_o = 1'b0;
    bus.idex_flush_o = 1'b0;
    bus.freeze_o     = 1'b0;
    if (bus.mem_wait_i) begin
      // Freeze stretches a stall window without consuming any of it.
      bus.freeze_o = 1'b1;
    end else if (bus.branch_taken_i) begin
      bus.ifid_flush_o = 1'b1;
      bus.idex_flush_o = 1'b1;
      state_n          = IDLE;
      rem_n            = 3'd0;
    end else if (state == LDSTALL) begin
      bus.pc_stall_o   = 1'b1;
      bus.ifid_stall_o = 1'b1;
      bus.idex_nop_o   = 1'b1;
      rem_n            = rem - 3'd1;
      if (rem == 3'd1) state_n = IDLE;
    end else if (hit) begin
      bus.pc_stall_o   = 1'b1;
      bus.ifid_stall_o = 1'b1;
      bus.idex_nop_o   = 1'b1;
      if (LOAD_LAT > 1) begin
        state_n = LDSTALL;
        rem_n   = 3'(LOAD_LAT - 1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rem       <= 3'd0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      if (bus.idex_nop_o && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.busy_o      = (state == LDSTALL);
  assign bus.stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three configurations (LOAD_LAT 1/3/2, CNT_W 16/16/4) share one stimulus
// stream and are compared against a bubble-budget model every cycle.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mr = 1'b0, urs = 1'b0, urt = 1'b0, br = 1'b0, mw = 1'b0;
  logic [4:0] rt_ex = '0, rs_id = '0, rt_id = '0;
  int         checks = 0;
  int         errors = 0;

  // model: bubbles still owed after the current one, and bubbles counted so far
  int lat [3] = '{1, 3, 2};
  int cmax[3] = '{65535, 65535, 15};
  int pend[3];
  int cnt [3];

  logic [6:0] act_ctl[3];
  int         act_cnt[3];

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if_a();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if_b();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  if_c();

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a.slave));
  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b.slave));
  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(4))  dut_c (.clk_i(clk), .rst_i(rst), .bus(if_c.slave));

  `define DRIVE_IF(IFN) \
    assign IFN.memread_idex_i = mr;    assign IFN.rt_idex_i = rt_ex; \
    assign IFN.rs_ifid_i = rs_id;      assign IFN.rt_ifid_i = rt_id; \
    assign IFN.use_rs_ifid_i = urs;    assign IFN.use_rt_ifid_i = urt; \
    assign IFN.branch_taken_i = br;    assign IFN.mem_wait_i = mw;
  `DRIVE_IF(if_a)
  `DRIVE_IF(if_b)
  `DRIVE_IF(if_c)

  assign act_ctl[0] = {if_a.pc_stall_o, if_a.ifid_stall_o, if_a.idex_nop_o, if_a.ifid_flush_o,
                       if_a.idex_flush_o, if_a.freeze_o, if_a.busy_o};
  assign act_ctl[1] = {if_b.pc_stall_o, if_b.ifid_stall_o, if_b.idex_nop_o, if_b.ifid_flush_o,
                       if_b.idex_flush_o, if_b.freeze_o, if_b.busy_o};
  assign act_ctl[2] = {if_c.pc_stall_o, if_c.ifid_stall_o, if_c.idex_nop_o, if_c.ifid_flush_o,
                       if_c.idex_flush_o, if_c.freeze_o, if_c.busy_o};
  assign act_cnt[0] = 32'(if_a.stall_cnt_o);
  assign act_cnt[1] = 32'(if_b.stall_cnt_o);
  assign act_cnt[2] = 32'(if_c.stall_cnt_o);

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      pend[k] = 0;
      cnt[k]  = 0;
    end
  endtask

  // Applies one cycle of inputs, checks every configuration, then advances the model past the edge.
  task automatic step(input logic s_mr, input logic [4:0] s_rt_ex, input logic [4:0] s_rs_id,
                      input logic [4:0] s_rt_id, input logic s_urs, input logic s_urt,
                      input logic s_br, input logic s_mw, input string tag);
    logic       hz, bub;
    logic [6:0] exp_ctl;
    @(negedge clk);
    mr = s_mr; rt_ex = s_rt_ex; rs_id = s_rs_id; rt_id = s_rt_id;
    urs = s_urs; urt = s_urt; br = s_br; mw = s_mw;
    #1;
    hz = s_mr && (s_rt_ex != 0) && ((s_urs && s_rs_id == s_rt_ex) || (s_urt && s_rt_id == s_rt_ex));
    for (int k = 0; k < 3; k++) begin
      bub = 1'b0;
      exp_ctl = '0;
      exp_ctl[0] = (pend[k] > 0);
      if (s_mw) exp_ctl[1] = 1'b1;
      else if (s_br) begin
        exp_ctl[3] = 1'b1; exp_ctl[2] = 1'b1;
      end else if (pend[k] > 0 || hz) bub = 1'b1;
      if (bub) exp_ctl[6:4] = 3'b111;
      checks++;
      assert (act_ctl[k] === exp_ctl)
        else begin errors++; $error("FAIL %s ctl dut%0d: got %b want %b", tag, k, act_ctl[k], exp_ctl); end
      checks++;
      assert (act_cnt[k] === cnt[k])
        else begin errors++; $error("FAIL %s cnt dut%0d: got %0d want %0d", tag, k, act_cnt[k], cnt[k]); end
      if (!s_mw) begin
        if (s_br) pend[k] = 0;
        else if (pend[k] > 0) pend[k] = pend[k] - 1;
        else if (hz) pend[k] = lat[k] - 1;
        if (bub && cnt[k] < cmax[k]) cnt[k] = cnt[k] + 1;
      end
    end
  endtask

  task automatic idle(input string tag);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic hazard(input string tag);
    step(1'b1, 5'd8, 5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    mr = 1'b0; urs = 1'b0; urt = 1'b0; br = 1'b0; mw = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      assert (act_ctl[k] === 7'b0)
        else begin errors++; $error("FAIL %s rst_ctl dut%0d: got %b want 0", tag, k, act_ctl[k]); end
      checks++;
      assert (act_cnt[k] === 0)
        else begin errors++; $error("FAIL %s rst_cnt dut%0d: got %0d want 0", tag, k, act_cnt[k]); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    pulse_reset("reset");
    idle("idle0");
    // basic load-use on rs, then EX cleared while the longer stalls run out
    hazard("hit_rs");
    idle("drain1");
    idle("drain2");
    idle("drain3");
    // load-use through rt
    step(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, "hit_rt");
    repeat (3) idle("drain_rt");
    // non-hazards: load to r0, unused rt
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, "r0_load");
    step(1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, "unused_rt");
    step(1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, "not_load");
    // freeze during the second bubble
    hazard("fz_hit");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, "fz_wait1");
    step(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, "fz_wait2");
    repeat (3) idle("fz_resume");
    // branch with a hit, and branch inside a stall
    step(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, "br_hit");
    idle("br_after");
    hazard("br_stall_hit");
    step(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, "br_in_stall");
    repeat (2) idle("br_cancel");
    // saturation of the 4-bit counter
    for (int i = 0; i < 18; i++) begin
      hazard("sat_hit");
      repeat (2) idle("sat_gap");
    end
    // reset aborting a stall
    hazard("rst_hit");
    pulse_reset("rst_mid");
    repeat (3) idle("post_rst");
    // randomized traffic over a small register set to keep hits frequent
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), "rand");
    end
    repeat (4) idle("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the 5-stage MIPS pipeline, sitting beside the ID stage and driving the PC, IF/ID and ID/EX pipeline registers. It detects load-use hazards with a configurable load-to-use latency, stalling for multiple cycles through an internal counter FSM. It also arbitrates taken-branch flushes and a memory-wait freeze. A saturating counter records stall cycles for performance measurement.

## Interface
- REG_AW, default 5: register-address width.
- LOAD_LAT, default 1: bubbles inserted per load-use hazard; legal range 1..7.
- CNT_W, default 16: width of the stall-cycle statistics counter.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- memread_idex_i  in  1  instruction in EX is a load.
- rt_idex_i  in  REG_AW  load destination register in EX.
- rs_ifid_i  in  REG_AW  rs field of the instruction in ID.
- rt_ifid_i  in  REG_AW  rt field of the instruction in ID.
- use_rs_ifid_i  in  1  instruction in ID actually reads rs.
- use_rt_ifid_i  in  1  instruction in ID actually reads rt.
- branch_taken_i  in  1  branch in EX resolved taken.
- mem_wait_i  in  1  data/instruction memory not ready; freeze whole pipe.
- pc_stall_o  out  1  hold PC.
- ifid_stall_o  out  1  hold IF/ID register.
- idex_nop_o  out  1  load all-zero control (bubble) into ID/EX.
- ifid_flush_o  out  1  clear IF/ID register.
- idex_flush_o  out  1  clear ID/EX register.
- freeze_o  out  1  hold every pipeline register, no bubble.
- busy_o  out  1  FSM is in LDSTALL.
- stall_cnt_o  out  CNT_W  saturating count of bubble cycles.

## Operation
- hit = memread_idex_i & (rt_idex_i != 0) & ((use_rs_ifid_i & rs_ifid_i == rt_idex_i) | (use_rt_ifid_i & rt_ifid_i == rt_idex_i)). A load to $zero never hits; an unused operand field never hits.
- State: FSM {IDLE, LDSTALL}, remaining-cycle counter rem (3 bits), stall_cnt.
- Priority, highest first:
  - mem_wait_i=1: freeze_o=1 and all other control outputs are 0. FSM, rem and stall_cnt hold. branch_taken_i is ignored this cycle.
  - branch_taken_i=1: ifid_flush_o=idex_flush_o=1 and stall outputs are 0. The next state is IDLE with rem=0, which cancels any pending stall.
  - LDSTALL: pc_stall_o=ifid_stall_o=idex_nop_o=1 and hit is not evaluated. rem decrements each cycle. If rem==1, the next state is IDLE.
  - IDLE with hit=1: pc_stall_o=ifid_stall_o=idex_nop_o=1. If LOAD_LAT>1, the next state is LDSTALL with rem=LOAD_LAT-1. Otherwise the FSM stays in IDLE.
  - Otherwise all outputs are 0.
- stall_cnt increments on every edge where idex_nop_o=1. It saturates at 2^CNT_W-1 and does not wrap.
- busy_o = (state == LDSTALL).

## Timing
- Reset: state IDLE, rem=0, stall_cnt_o=0, busy_o=0. All control outputs are 0 while inputs are idle; reset asserted mid-stall aborts the stall immediately.
- Control outputs are combinational from inputs and current state, with zero latency to the same-cycle register enables.
- Each load-use hazard produces exactly LOAD_LAT consecutive bubble cycles, excluding freeze cycles, which extend the window without consuming it.
- busy_o rises one cycle after detection (LOAD_LAT>1) and falls after the final bubble cycle.
- stall_cnt_o reflects a bubble on the clock edge that ends that bubble cycle.

## Test plan
- LOAD_LAT=1, load into r8 in EX, ID reads rs=8 with use_rs=1 -> one cycle of pc_stall/ifid_stall/idex_nop=1, busy_o stays 0, stall_cnt_o 0->1.
- LOAD_LAT=3, same hazard -> three bubble cycles, busy_o high in cycles 2-3, stall_cnt_o=3; with the EX inputs cleared after cycle 1, the stall still lasts three cycles.
- Load into r0 with ID rs=0, and separately a load into r9 with rt_ifid=9 but use_rt=0 -> no stall, all outputs 0.
- LOAD_LAT=3, mem_wait_i=1 for 2 cycles during the second bubble cycle -> freeze_o=1 for those 2 cycles with the others 0, then the remaining bubbles resume; total idex_nop cycles =3.
- branch_taken_i=1 simultaneous with a hit, and again while in LDSTALL -> ifid_flush_o=idex_flush_o=1, no stall, next state IDLE, stall_cnt unchanged.
- CNT_W=4, sixteen or more hazards -> stall_cnt_o saturates at 15; rst_i pulse mid-LDSTALL -> busy_o=0 and stall_cnt_o=0 immediately.
